// File: rtl/if_prefetch_queue_if.sv
// Bundle of the fetch-side (RIB) and decode-side signals of the prefetch queue.
// Handshake: a fetch beat transfers on a clock edge where rib_valid_i and
// rib_ready_o are both high. rib_valid_i must not depend on rib_ready_o.
// The decode side sees the head entry through inst_valid_o. The head is
// consumed on any edge where inst_valid_o is high and hold_i and flush_i are
// both low.
interface if_prefetch_queue_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32,
  parameter int INT_W  = 8,
  parameter int DEPTH  = 4
);
  localparam int LVL_W = $clog2(DEPTH) + 1;

  logic              rib_valid_i;
  logic [DATA_W-1:0] rib_inst_i;
  logic [ADDR_W-1:0] rib_inst_addr_i;
  logic [INT_W-1:0]  int_flag_i;
  logic              rib_ready_o;
  logic              hold_i;
  logic              flush_i;
  logic [ADDR_W-1:0] flush_addr_i;
  logic              inst_valid_o;
  logic [DATA_W-1:0] inst_o;
  logic [ADDR_W-1:0] inst_addr_o;
  logic [INT_W-1:0]  int_flag_o;
  logic [LVL_W-1:0]  level_o;

  // Driver side: fetch unit plus ctrl/decode stimulus.
  modport master (
    output rib_valid_i, rib_inst_i, rib_inst_addr_i, int_flag_i,
    output hold_i, flush_i, flush_addr_i,
    input  rib_ready_o, inst_valid_o, inst_o, inst_addr_o, int_flag_o, level_o
  );

  // Queue side.
  modport slave (
    input  rib_valid_i, rib_inst_i, rib_inst_addr_i, int_flag_i,
    input  hold_i, flush_i, flush_addr_i,
    output rib_ready_o, inst_valid_o, inst_o, inst_addr_o, int_flag_o, level_o
  );
endinterface

// File: rtl/if_prefetch_queue.sv
// Instruction prefetch queue between the RIB instruction port and decode.
// DEPTH-entry FIFO of {inst, addr, int_flag}. Decode hold stops pops, and a
// jump flush empties the queue. After a flush, a small filter drops fetch
// beats from the old path until the beat at the jump target arrives.
module if_prefetch_queue #(
  parameter int                 DATA_W   = 32,
  parameter int                 ADDR_W   = 32,
  parameter int                 INT_W    = 8,
  parameter int                 DEPTH    = 4,
  parameter logic [DATA_W-1:0]  NOP_INST = DATA_W'(32'h0000_0013)
) (
  input  logic                 clk_i,
  input  logic                 rst_n_i,
  if_prefetch_queue_if.slave   bus,
  output logic                 filter_armed_o
);
  localparam int               PTR_W   = $clog2(DEPTH);
  localparam int               LVL_W   = PTR_W + 1;
  localparam logic [LVL_W-1:0] DEPTH_L = LVL_W'(DEPTH);

  typedef enum logic {
    FILT_IDLE  = 1'b0,
    FILT_ARMED = 1'b1
  } filt_state_e;

  filt_state_e       state_q, state_d;
  logic [ADDR_W-1:0] expect_q, expect_d;

  logic [DATA_W-1:0] mem_inst [DEPTH];
  logic [ADDR_W-1:0] mem_addr [DEPTH];
  logic [INT_W-1:0]  mem_int  [DEPTH];

  logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
  logic [LVL_W-1:0]  level_q;

  logic head_valid, pop, push, rib_ready, addr_match, filter_pass;

  // Handshake qualifiers. When full, a pop in the same cycle frees a slot,
  // so ready depends combinationally on hold_i and flush_i.
  always_comb begin
    head_valid  = (level_q != '0);
    pop         = head_valid & ~bus.hold_i & ~bus.flush_i;
    rib_ready   = (level_q < DEPTH_L) | pop;
    addr_match  = (bus.rib_inst_addr_i == expect_q);
    filter_pass = (state_q == FILT_IDLE) | addr_match;
    push        = bus.rib_valid_i & rib_ready & ~bus.flush_i & filter_pass;
  end

  // Head outputs are read straight from the array and masked while empty.
  always_comb begin
    bus.rib_ready_o  = rib_ready;
    bus.inst_valid_o = head_valid;
    bus.level_o      = level_q;
    bus.inst_o       = NOP_INST;
    bus.inst_addr_o  = '0;
    bus.int_flag_o   = '0;
    if (head_valid) begin
      bus.inst_o      = mem_inst[rd_ptr_q];
      bus.inst_addr_o = mem_addr[rd_ptr_q];
      bus.int_flag_o  = mem_int[rd_ptr_q];
    end
  end

  assign filter_armed_o = (state_q == FILT_ARMED);

  // Entry storage. The contents need no reset because level gates every read.
  always_ff @(posedge clk_i) begin
    if (push) begin
      mem_inst[wr_ptr_q] <= bus.rib_inst_i;
      mem_addr[wr_ptr_q] <= bus.rib_inst_addr_i;
      mem_int[wr_ptr_q]  <= bus.int_flag_i;
    end
  end

  // Pointers and occupancy. A flush overrides everything and restarts at 0.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else if (bus.flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({push, pop})
        2'b10:   level_q <= level_q + 1'b1;
        2'b01:   level_q <= level_q - 1'b1;
        default: level_q <= level_q;
      endcase
    end
  end

  // Filter state register.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q  <= FILT_IDLE;
      expect_q <= '0;
    end else begin
      state_q  <= state_d;
      expect_q <= expect_d;
    end
  end

  // Filter next state: arm on every flush. Disarm once the jump target beat
  // has completed its handshake.
  always_comb begin
    state_d  = state_q;
    expect_d = expect_q;
    if (bus.flush_i) begin
      state_d  = FILT_ARMED;
      expect_d = bus.flush_addr_i;
    end else if (state_q == FILT_ARMED && bus.rib_valid_i && rib_ready && addr_match) begin
      state_d  = FILT_IDLE;
    end
  end

  // Occupancy can never exceed the array size.
  a_level_bound: assert property (@(posedge clk_i) disable iff (!rst_n_i) level_q <= DEPTH_L);

endmodule
